// File: rtl/timer_counter_pkg.sv
// Shared constants and types for the timer/counter front end: default timing,
// channel indices and the long-press FSM state type.
package timer_counter_pkg;

    localparam int DEB_CYCLES_DEF    = 20000;
    localparam int HOLD_CYCLES_DEF   = 5000000;
    localparam int REPEAT_CYCLES_DEF = 1000000;

    localparam int BTN_MODE  = 0;
    localparam int BTN_START = 1;
    localparam int BTN_STOP  = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        REPEAT = 1'b1
    } hold_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser, debounce with glitch rejection, press/release
// strobes and, when BTN_CONDITIONER_HOLD_EN is defined, long-press auto-repeat.
//
//   state  | meaning
//   IDLE   | button released, or held for less than HOLD_CYCLES
//   REPEAT | long press recognised, hold pulses every REPEAT_CYCLES
module btn_debounce_ch
    import timer_counter_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int SYNC_STAGES = 2,
    parameter bit ACTIVE_LOW  = 1'b0
`ifdef BTN_CONDITIONER_HOLD_EN
    ,
    parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic hold
);

    localparam int DEB_W = cnt_width(DEB_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DEB_W-1:0]       deb_cnt;
    logic                   stable;
    logic                   raw;
    logic                   accept;

    assign raw    = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;
    assign accept = (raw != stable) && (deb_cnt == DEB_LAST);
    assign level  = stable;

    // Synchroniser resets to the idle pin level so reset release looks like "not pressed".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q        <= {SYNC_STAGES{ACTIVE_LOW}};
            deb_cnt       <= '0;
            stable        <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync_q        <= {sync_q[SYNC_STAGES-2:0], btn_in};
            press         <= 1'b0;
            release_pulse <= 1'b0;
            if (raw == stable) begin
                deb_cnt <= '0;
            end else if (accept) begin
                stable        <= raw;
                deb_cnt       <= '0;
                press         <= raw;
                release_pulse <= ~raw;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

`ifdef BTN_CONDITIONER_HOLD_EN
    localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = cnt_width(HOLD_MAX);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYCLES - 1);

    hold_state_t       hold_state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              level_nxt;

    assign level_nxt = accept ? raw : stable;

    // Counting starts the cycle after the press edge, so the first hold lands
    // exactly HOLD_CYCLES after press; the release edge itself already clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_state <= IDLE;
            hold_cnt   <= '0;
            hold       <= 1'b0;
        end else begin
            hold <= 1'b0;
            if (!level_nxt) begin
                hold_state <= IDLE;
                hold_cnt   <= '0;
            end else if (stable) begin
                if (hold_state == IDLE) begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold       <= 1'b1;
                        hold_cnt   <= '0;
                        hold_state <= REPEAT;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end else begin
                    if (hold_cnt == REPEAT_LAST) begin
                        hold     <= 1'b1;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
            end
        end
    end
`else
    assign hold = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Debounced button/switch front end for the timer/counter core; N_BTN independent
// channels. Define BTN_CONDITIONER_HOLD_EN for long-press auto-repeat on hold.
// The release strobe is named release_pulse because "release" is a reserved word.
module btn_conditioner
    import timer_counter_pkg::*;
#(
    parameter int N_BTN         = 3,
    parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
    parameter int SYNC_STAGES   = 2,
    parameter bit ACTIVE_LOW    = 1'b0,
    parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] hold
);

    if (DEB_CYCLES < 2) begin : g_bad_deb
        $error("btn_conditioner: DEB_CYCLES must be >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("btn_conditioner: SYNC_STAGES must be >= 2");
    end
    if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_hold
        $error("btn_conditioner: HOLD_CYCLES and REPEAT_CYCLES must be >= 1");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEB_CYCLES   (DEB_CYCLES),
            .SYNC_STAGES  (SYNC_STAGES),
            .ACTIVE_LOW   (ACTIVE_LOW)
`ifdef BTN_CONDITIONER_HOLD_EN
            ,
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
`endif
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .btn_in       (btn_in[i]),
            .level        (level[i]),
            .press        (press[i]),
            .release_pulse(release_pulse[i]),
            .hold         (hold[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: vector table for press/bounce/glitch/simultaneous cases,
// plus hand sequences for long-press hold and reset mid-debounce with ACTIVE_LOW=1.
module tb_btn_conditioner;
    import timer_counter_pkg::*;

    localparam int N = 3;

`ifdef BTN_CONDITIONER_HOLD_EN
    localparam bit HOLD_ON = 1'b1;
`else
    localparam bit HOLD_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n, rst_al_n;
    logic [N-1:0] btn, btn_al;
    logic [N-1:0] level, press, rel, hold;
    logic [N-1:0] level_al, press_al, rel_al, hold_al;

    int n_checks = 0;
    int n_errors = 0;
    int press_cnt[N];
    int rel_cnt[N];

    always #5 clk = ~clk;

    btn_conditioner #(
        .N_BTN(N), .DEB_CYCLES(8), .SYNC_STAGES(2), .ACTIVE_LOW(1'b0),
        .HOLD_CYCLES(20), .REPEAT_CYCLES(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn),
        .level(level), .press(press), .release_pulse(rel), .hold(hold)
    );

    btn_conditioner #(
        .N_BTN(N), .DEB_CYCLES(8), .SYNC_STAGES(2), .ACTIVE_LOW(1'b1),
        .HOLD_CYCLES(20), .REPEAT_CYCLES(5)
    ) dut_al (
        .clk(clk), .rst_n(rst_al_n), .btn_in(btn_al),
        .level(level_al), .press(press_al), .release_pulse(rel_al), .hold(hold_al)
    );

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (press[i]) press_cnt[i]++;
            if (rel[i])   rel_cnt[i]++;
        end
    end

    typedef struct {
        logic [N-1:0] btn;
        int           n;
        logic [N-1:0] lvl;
        logic [N-1:0] prs;
        logic [N-1:0] rls;
    } vec_t;

    vec_t vecs[27];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // clean press/release on ch0
        vecs[0]  = '{3'b000,  3, 3'b000, 3'b000, 3'b000};
        vecs[1]  = '{3'b001,  9, 3'b000, 3'b000, 3'b000};
        vecs[2]  = '{3'b001,  1, 3'b001, 3'b001, 3'b000};
        vecs[3]  = '{3'b001,  1, 3'b001, 3'b000, 3'b000};
        vecs[4]  = '{3'b000,  9, 3'b001, 3'b000, 3'b000};
        vecs[5]  = '{3'b000,  1, 3'b000, 3'b000, 3'b001};
        vecs[6]  = '{3'b000,  1, 3'b000, 3'b000, 3'b000};
        // bounce on ch1, then settle high
        vecs[7]  = '{3'b010,  3, 3'b000, 3'b000, 3'b000};
        vecs[8]  = '{3'b000,  3, 3'b000, 3'b000, 3'b000};
        vecs[9]  = '{3'b010,  3, 3'b000, 3'b000, 3'b000};
        vecs[10] = '{3'b000,  3, 3'b000, 3'b000, 3'b000};
        vecs[11] = '{3'b010,  9, 3'b000, 3'b000, 3'b000};
        vecs[12] = '{3'b010,  1, 3'b010, 3'b010, 3'b000};
        vecs[13] = '{3'b010,  1, 3'b010, 3'b000, 3'b000};
        vecs[14] = '{3'b000, 10, 3'b000, 3'b000, 3'b010};
        vecs[15] = '{3'b000,  1, 3'b000, 3'b000, 3'b000};
        // glitches on ch2: two 1-cycle pulses, one 7-cycle pulse
        vecs[16] = '{3'b100,  1, 3'b000, 3'b000, 3'b000};
        vecs[17] = '{3'b000,  5, 3'b000, 3'b000, 3'b000};
        vecs[18] = '{3'b100,  1, 3'b000, 3'b000, 3'b000};
        vecs[19] = '{3'b000,  5, 3'b000, 3'b000, 3'b000};
        vecs[20] = '{3'b100,  7, 3'b000, 3'b000, 3'b000};
        vecs[21] = '{3'b000, 12, 3'b000, 3'b000, 3'b000};
        // all three together
        vecs[22] = '{3'b111,  9, 3'b000, 3'b000, 3'b000};
        vecs[23] = '{3'b111,  1, 3'b111, 3'b111, 3'b000};
        vecs[24] = '{3'b111,  1, 3'b111, 3'b000, 3'b000};
        vecs[25] = '{3'b000, 10, 3'b000, 3'b000, 3'b111};
        vecs[26] = '{3'b000,  1, 3'b000, 3'b000, 3'b000};

        rst_n    = 1'b0;
        rst_al_n = 1'b0;
        btn      = '0;
        btn_al   = '1;
        step();
        step();
        chk("reset.level",    32'(level),    32'(0));
        chk("reset.press",    32'(press),    32'(0));
        chk("reset.release",  32'(rel),      32'(0));
        chk("reset.hold",     32'(hold),     32'(0));
        chk("reset_al.level", 32'(level_al), 32'(0));
        rst_n    = 1'b1;
        rst_al_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            btn = vecs[i].btn;
            repeat (vecs[i].n) step();
            chk($sformatf("vec%0d.level", i),   32'(level), 32'(vecs[i].lvl));
            chk($sformatf("vec%0d.press", i),   32'(press), 32'(vecs[i].prs));
            chk($sformatf("vec%0d.release", i), 32'(rel),   32'(vecs[i].rls));
            chk($sformatf("vec%0d.hold", i),    32'(hold),  32'(0));
        end

        for (int i = 0; i < N; i++) begin
            chk($sformatf("press_count%0d", i), 32'(press_cnt[i]), 32'((i == BTN_STOP) ? 1 : 2));
            chk($sformatf("release_count%0d", i), 32'(rel_cnt[i]), 32'((i == BTN_STOP) ? 1 : 2));
        end

        // long press on ch0: press at edge 10, hold at 30,35,...; released at edge 55
        btn[BTN_MODE] = 1'b1;
        for (int k = 1; k <= 65; k++) begin
            step();
            chk($sformatf("hold_seq%0d.level", k), 32'(level[BTN_MODE]),
                32'(k >= 10 && k < 55));
            chk($sformatf("hold_seq%0d.press", k), 32'(press[BTN_MODE]), 32'(k == 10));
            chk($sformatf("hold_seq%0d.release", k), 32'(rel[BTN_MODE]), 32'(k == 55));
            chk($sformatf("hold_seq%0d.hold", k), 32'(hold[BTN_MODE]),
                32'(HOLD_ON && k >= 30 && k < 55 && ((k - 30) % 5) == 0));
            if (k == 45) btn[BTN_MODE] = 1'b0;
        end

        // ACTIVE_LOW instance: ch1 pressed, ch0 mid-count when reset hits
        btn_al[BTN_START] = 1'b0;
        repeat (10) step();
        chk("al_press1.level", 32'(level_al), 32'(3'b010));
        chk("al_press1.press", 32'(press_al), 32'(3'b010));
        btn_al[BTN_MODE] = 1'b0;
        repeat (7) step();
        chk("al_midcount.level", 32'(level_al), 32'(3'b010));
        chk("al_midcount.press", 32'(press_al), 32'(3'b000));
        #2 rst_al_n = 1'b0;
        #1;
        chk("al_async_rst.level",   32'(level_al), 32'(0));
        chk("al_async_rst.press",   32'(press_al), 32'(0));
        chk("al_async_rst.release", 32'(rel_al),   32'(0));
        step();
        step();
        chk("al_in_rst.level", 32'(level_al), 32'(0));
        rst_al_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("al_after_rst%0d.level", k), 32'(level_al),
                32'((k >= 10) ? 3'b011 : 3'b000));
            chk($sformatf("al_after_rst%0d.press", k), 32'(press_al),
                32'((k == 10) ? 3'b011 : 3'b000));
            chk($sformatf("al_after_rst%0d.release", k), 32'(rel_al), 32'(0));
            chk($sformatf("al_after_rst%0d.hold", k), 32'(hold_al), 32'(0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
